// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared state encoding, operation codes and saturation limits for the
// digit-serial adder/subtractor.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   localparam int MAX_W = 64;

   // Signed limit of a width-bit word: min (1000..0) when neg, else max (0111..1).
   function automatic logic [MAX_W-1:0] sat_limit(input int width, input logic neg);
      logic [MAX_W-1:0] msb;
      msb = '0;
      msb[width-1] = 1'b1;
      return neg ? msb : (msb - 64'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rca_nbits.sv
// ---------------------------------------------------------------------------
// rca_nbits
// Combinational n-bit ripple-carry adder with carry in and carry out.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rca_nbits #(
   parameter int n = 4
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         cin,
   output logic [n-1:0] sum,
   output logic         cout
);

   logic [n:0] w_c;

   assign w_c[0] = cin;

   generate
      for (genvar i = 0; i < n; i++) begin : g_bit
         assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
         assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout = w_c[n];

endmodule

`default_nettype wire

// File: rtl/addsub_digit_serial.sv
// ---------------------------------------------------------------------------
// addsub_digit_serial
// Multi-cycle N-bit add/subtract, CHUNK bits per clock LSB first, with flags,
// optional signed saturation and valid/ready handshakes on both sides.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module addsub_digit_serial
   import addsub_pkg::*;
#(
   parameter int N     = 16,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         add_n,
   input  logic         sat_en,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         ovf,
   output logic         zero
);

   localparam int NSTEP = N / CHUNK;
   localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

   generate
      if ((CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0)) begin : g_bad_chunk
         $error("addsub_digit_serial: CHUNK must divide N");
      end
   endgenerate

   state_t          r_state;
   logic [SW-1:0]   r_step;
   logic [N-1:0]    r_x;
   logic [N-1:0]    r_y;
   logic            r_carry;
   logic            r_sat;
   logic            r_x_msb;
   logic            r_y_msb;
   logic            r_out_valid;
   logic [N-1:0]    r_s;
   logic            r_cout;
   logic            r_ovf;
   logic            r_zero;

   logic [CHUNK-1:0] w_chunk_sum;
   logic             w_chunk_cout;
   logic [N-1:0]     w_x_next;
   logic [N-1:0]     w_y_next;
   logic [N-1:0]     w_s_next;
   logic [N-1:0]     w_sat_val;
   logic [N-1:0]     w_final;
   logic             w_ovf;

   rca_nbits #(.n(CHUNK)) u_rca (
      .a    (r_x[CHUNK-1:0]),
      .b    (r_y[CHUNK-1:0]),
      .cin  (r_carry),
      .sum  (w_chunk_sum),
      .cout (w_chunk_cout)
   );

   // Operands shift down one chunk per step; the sum fills s from the top.
   generate
      if (NSTEP == 1) begin : g_single
         assign w_x_next = r_x;
         assign w_y_next = r_y;
         assign w_s_next = w_chunk_sum;
      end else begin : g_multi
         assign w_x_next = {{CHUNK{1'b0}}, r_x[N-1:CHUNK]};
         assign w_y_next = {{CHUNK{1'b0}}, r_y[N-1:CHUNK]};
         assign w_s_next = {w_chunk_sum, r_s[N-1:CHUNK]};
      end
   endgenerate

   assign w_ovf     = (r_x_msb == r_y_msb) && (w_s_next[N-1] != r_x_msb);
   assign w_sat_val = N'(sat_limit(N, r_x_msb));
   assign w_final   = (r_sat && w_ovf) ? w_sat_val : w_s_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_step      <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_carry     <= 1'b0;
         r_sat       <= 1'b0;
         r_x_msb     <= 1'b0;
         r_y_msb     <= 1'b0;
         r_out_valid <= 1'b0;
         r_s         <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_x     <= x;
                  r_y     <= y ^ {N{add_n}};
                  r_carry <= add_n;
                  r_sat   <= sat_en;
                  r_x_msb <= x[N-1];
                  r_y_msb <= y[N-1] ^ add_n;
                  r_step  <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_x     <= w_x_next;
               r_y     <= w_y_next;
               r_carry <= w_chunk_cout;
               r_step  <= r_step + SW'(1);
               if (r_step == LAST_STEP) begin
                  r_s         <= w_final;
                  r_cout      <= w_chunk_cout;
                  r_ovf       <= w_ovf;
                  r_zero      <= (w_final == '0);
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_s <= w_s_next;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE) && !reset;
   assign out_valid = r_out_valid;
   assign s         = r_s;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_addsub_digit_serial.sv
// ---------------------------------------------------------------------------
// tb_addsub_digit_serial
// Scoreboard bench driving N=8 instances with CHUNK=4, 8 and 1 in lockstep.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_addsub_digit_serial;
   import addsub_pkg::*;

   localparam int N = 8;

   typedef struct packed {
      logic [N-1:0] s;
      logic         c;
      logic         o;
      logic         z;
   } res_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         out_ready;
   logic [N-1:0] x;
   logic [N-1:0] y;
   logic         add_n;
   logic         sat_en;
   logic [2:0]   rdy;
   logic [2:0]   vld;
   logic [2:0]   co;
   logic [2:0]   ov;
   logic [2:0]   zr;
   logic [N-1:0] s_arr [3];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_lat [3] = '{2, 1, 8};
   res_t sb0[$];
   res_t sb1[$];
   res_t sb2[$];

   always #5 clk = ~clk;

   addsub_digit_serial #(.N(N), .CHUNK(4)) u_c4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
      .x(x), .y(y), .add_n(add_n), .sat_en(sat_en), .out_valid(vld[0]),
      .out_ready(out_ready), .s(s_arr[0]), .cout(co[0]), .ovf(ov[0]), .zero(zr[0]));

   addsub_digit_serial #(.N(N), .CHUNK(8)) u_c8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
      .x(x), .y(y), .add_n(add_n), .sat_en(sat_en), .out_valid(vld[1]),
      .out_ready(out_ready), .s(s_arr[1]), .cout(co[1]), .ovf(ov[1]), .zero(zr[1]));

   addsub_digit_serial #(.N(N), .CHUNK(1)) u_c1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
      .x(x), .y(y), .add_n(add_n), .sat_en(sat_en), .out_valid(vld[2]),
      .out_ready(out_ready), .s(s_arr[2]), .cout(co[2]), .ovf(ov[2]), .zero(zr[2]));

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference built from wide signed arithmetic rather than the carry chain.
   function automatic res_t model(input logic [N-1:0] xv, input logic [N-1:0] yv,
                                  input logic an, input logic se);
      res_t     r;
      logic [N:0] full;
      int       sr;
      if (an) begin
         full = {1'b0, xv} + {1'b0, ~yv} + 9'd1;
         sr   = int'($signed(xv)) - int'($signed(yv));
      end else begin
         full = {1'b0, xv} + {1'b0, yv};
         sr   = int'($signed(xv)) + int'($signed(yv));
      end
      r.o = (sr > 127) || (sr < -128);
      r.s = full[N-1:0];
      if (se && r.o) r.s = (sr > 127) ? 8'h7F : 8'h80;
      r.c = full[N];
      r.z = (r.s == 8'h00);
      return r;
   endfunction

   task automatic take(input int i, output res_t r, output bit ok);
      ok = 1'b1;
      r  = '0;
      case (i)
         0: if (sb0.size() > 0) r = sb0.pop_front(); else ok = 1'b0;
         1: if (sb1.size() > 0) r = sb1.pop_front(); else ok = 1'b0;
         default: if (sb2.size() > 0) r = sb2.pop_front(); else ok = 1'b0;
      endcase
   endtask

   // Starts and ends just after a falling edge.
   task automatic do_txn(input logic [N-1:0] xv, input logic [N-1:0] yv,
                         input logic an, input logic se, input int bp);
      res_t   e;
      res_t   got;
      bit     ok;
      logic [2:0] seen;
      int     c;
      check_value("in_ready_idle", {29'd0, rdy}, 32'h7);
      x = xv; y = yv; add_n = an; sat_en = se; in_valid = 1'b1;
      e = model(xv, yv, an, se);
      sb0.push_back(e); sb1.push_back(e); sb2.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      x = N'($urandom); y = N'($urandom); add_n = ~an; sat_en = ~se;
      check_value("in_ready_busy", {29'd0, rdy & ~vld}, 32'h0);
      seen = 3'b000;
      c = 0;
      while (seen != 3'b111 && c <= 12) begin
         for (int i = 0; i < 3; i++) begin
            if (!seen[i] && vld[i]) begin
               seen[i] = 1'b1;
               take(i, got, ok);
               check_value($sformatf("c%0d_unexpected_valid", i), {31'd0, ok}, 32'd1);
               check_value($sformatf("c%0d_latency", i), c, exp_lat[i]);
               check_value($sformatf("c%0d_s", i), {24'd0, s_arr[i]}, {24'd0, got.s});
               check_value($sformatf("c%0d_cout", i), {31'd0, co[i]}, {31'd0, got.c});
               check_value($sformatf("c%0d_ovf", i), {31'd0, ov[i]}, {31'd0, got.o});
               check_value($sformatf("c%0d_zero", i), {31'd0, zr[i]}, {31'd0, got.z});
            end
         end
         if (seen != 3'b111) begin
            @(negedge clk);
            c++;
         end
      end
      if (seen != 3'b111) check_value("out_valid_timeout", {29'd0, seen}, 32'h7);
      for (int k = 0; k < bp; k++) begin
         in_valid = 1'b1;
         x = N'($urandom); y = N'($urandom);
         @(negedge clk);
         check_value("bp_valid", {29'd0, vld}, 32'h7);
         check_value("bp_in_ready", {29'd0, rdy}, 32'h0);
         check_value("bp_s_c4", {24'd0, s_arr[0]}, {24'd0, e.s});
         check_value("bp_s_c1", {24'd0, s_arr[2]}, {24'd0, e.s});
         check_value("bp_flags_c4", {29'd0, co[0], ov[0], zr[0]}, {29'd0, e.c, e.o, e.z});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_value("valid_drop", {29'd0, vld}, 32'h0);
      check_value("s_hold", {24'd0, s_arr[1]}, {24'd0, e.s});
   endtask

   task automatic reset_mid_run();
      logic [2:0] any_valid;
      x = 8'h3C; y = 8'h15; add_n = ADD; sat_en = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_value("rst_mid_valid", {29'd0, vld}, 32'h0);
      check_value("rst_mid_ready", {29'd0, rdy}, 32'h0);
      check_value("rst_mid_s", {24'd0, s_arr[0]}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check_value("rdy_after_release", {29'd0, rdy}, 32'h7);
      any_valid = 3'b000;
      repeat (12) begin
         @(negedge clk);
         any_valid |= vld;
      end
      check_value("stale_valid", {29'd0, any_valid}, 32'h0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      x = '0; y = '0; add_n = ADD; sat_en = 1'b0;
      repeat (2) @(negedge clk);
      check_value("rst_valid", {29'd0, vld}, 32'h0);
      check_value("rst_ready", {29'd0, rdy}, 32'h0);
      check_value("rst_flags", {29'd0, co | ov | zr}, 32'h0);
      for (int i = 0; i < 3; i++)
         check_value($sformatf("rst_s_c%0d", i), {24'd0, s_arr[i]}, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      do_txn(8'h3C, 8'h15, ADD, 1'b0, 0);
      do_txn(8'h10, 8'h20, SUB, 1'b0, 0);
      do_txn(8'h20, 8'h10, SUB, 1'b0, 0);
      do_txn(8'h70, 8'h20, ADD, 1'b0, 0);
      do_txn(8'h70, 8'h20, ADD, 1'b1, 0);
      do_txn(8'h80, 8'h01, SUB, 1'b1, 0);
      do_txn(8'h80, 8'h01, SUB, 1'b0, 0);
      do_txn(8'h55, 8'h55, SUB, 1'b0, 0);
      do_txn(8'hA5, 8'h3C, ADD, 1'b1, 5);
      do_txn(8'h7F, 8'h01, ADD, 1'b1, 0);
      reset_mid_run();
      do_txn(8'h12, 8'h34, SUB, 1'b0, 0);
      do_txn(8'hFF, 8'h01, ADD, 1'b0, 0);

      check_value("sb_leftover", sb0.size() + sb1.size() + sb2.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
